amo_queue: RTL and testbench

//  Multi-entry, in-order buffer for atomic memory operations (AMOs) between the load/store unit and the D$ AMO port.

---
 rtl/amo_queue.sv | 141 ++++++++++++++
 tb/tb_amo_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_queue.sv
// In-order AMO buffer between the LSU and the D$ AMO port: entries are pushed speculatively,
// committed in program order, and only committed entries are issued once the store buffer is empty.
module amo_queue #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [3:0]                   amo_op_i,
    input  logic [PLEN-1:0]              paddr_i,
    input  logic [XLEN-1:0]              data_i,
    input  logic [1:0]                   data_size_i,
    input  logic [TRANS_ID_BITS-1:0]     trans_id_i,
    input  logic                         commit_i,
    input  logic                         no_st_pending_i,
    output logic                         amo_req_req_o,
    output logic [3:0]                   amo_req_amo_op_o,
    output logic [1:0]                   amo_req_size_o,
    output logic [63:0]                  amo_req_operand_a_o,
    output logic [63:0]                  amo_req_operand_b_o,
    input  logic                         amo_resp_ack_i,
    input  logic [63:0]                  amo_resp_result_i,
    output logic                         result_valid_o,
    output logic [XLEN-1:0]              result_o,
    output logic [TRANS_ID_BITS-1:0]     result_trans_id_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned UW = $clog2(DEPTH + 1);

    logic [3:0]               op_q     [DEPTH];
    logic [PLEN-1:0]          paddr_q  [DEPTH];
    logic [XLEN-1:0]          data_q   [DEPTH];
    logic [1:0]               size_q   [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q     [DEPTH];
    logic [DEPTH-1:0]         valid_q, committed_q;
    logic [PW-1:0]            head_q, tail_q, commit_q;
    logic                     issued_q;
    logic                     result_valid_q;
    logic [XLEN-1:0]          result_q;
    logic [TRANS_ID_BITS-1:0] result_id_q;

    logic          req, commit_ok, do_commit, do_pop, do_push, ready;
    logic [PW-1:0] commit_d;
    logic [UW-1:0] usage;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    always_comb begin
        usage = '0;
        for (int i = 0; i < DEPTH; i++) usage = usage + UW'(valid_q[i]);
    end

    // commit_q points at the oldest uncommitted entry, or at tail when none exists
    assign commit_ok = valid_q[commit_q] & ~committed_q[commit_q];
    assign do_commit = commit_i & commit_ok;
    assign commit_d  = do_commit ? ptr_inc(commit_q) : commit_q;
    assign req       = valid_q[head_q] & committed_q[head_q] & (no_st_pending_i | issued_q);
    assign do_pop    = amo_resp_ack_i & req;
    assign ready     = (usage != UW'(DEPTH));
    assign do_push   = valid_i & ready & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q        <= '0;
            committed_q    <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            commit_q       <= '0;
            issued_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_id_q    <= '0;
        end else begin
            result_valid_q <= do_pop;
            if (do_pop) begin
                result_q    <= amo_resp_result_i[XLEN-1:0];
                result_id_q <= id_q[head_q];
            end
            if (do_pop)   issued_q <= 1'b0;
            else if (req) issued_q <= 1'b1;

            // a commit in the flush cycle lands first, so that entry survives
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !committed_q[i] && !(do_commit && commit_q == PW'(i)))
                        valid_q[i] <= 1'b0;
                end
                tail_q <= commit_d;
            end
            if (do_commit) begin
                committed_q[commit_q] <= 1'b1;
                commit_q              <= commit_d;
            end
            if (do_pop) begin
                valid_q[head_q]     <= 1'b0;
                committed_q[head_q] <= 1'b0;
                head_q              <= ptr_inc(head_q);
            end
            if (do_push) begin
                valid_q[tail_q]     <= 1'b1;
                committed_q[tail_q] <= 1'b0;
                tail_q              <= ptr_inc(tail_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            op_q[tail_q]    <= amo_op_i;
            paddr_q[tail_q] <= paddr_i;
            data_q[tail_q]  <= data_i;
            size_q[tail_q]  <= data_size_i;
            id_q[tail_q]    <= trans_id_i;
        end
    end

    assign ready_o             = ready;
    assign usage_o             = usage;
    assign amo_req_req_o       = req;
    assign amo_req_amo_op_o    = op_q[head_q];
    assign amo_req_size_o      = size_q[head_q];
    assign amo_req_operand_a_o = 64'(paddr_q[head_q]);
    assign amo_req_operand_b_o = 64'(data_q[head_q]);
    assign result_valid_o      = result_valid_q;
    assign result_o            = result_q;
    assign result_trans_id_o   = result_id_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni) commit_i |-> commit_ok)
        else $error("amo_queue: commit with no uncommitted entry");
    assert property (@(posedge clk_i) disable iff (!rst_ni) amo_resp_ack_i |-> req)
        else $error("amo_queue: ack without an outstanding request");
endmodule

// File: tb/tb_amo_queue.sv
// Bench for amo_queue: directed scenarios then random traffic, all checked against a
// queue-based model of the AMO buffer.
module tb_amo_queue;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, valid_i, ready_o, commit_i, no_st_pending_i;
    logic [3:0]  amo_op_i;
    logic [55:0] paddr_i;
    logic [63:0] data_i;
    logic [1:0]  data_size_i;
    logic [2:0]  trans_id_i;
    logic        amo_req_req_o;
    logic [3:0]  amo_req_amo_op_o;
    logic [1:0]  amo_req_size_o;
    logic [63:0] amo_req_operand_a_o, amo_req_operand_b_o;
    logic        amo_resp_ack_i;
    logic [63:0] amo_resp_result_i;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic [2:0]  result_trans_id_o;
    logic [1:0]  usage_o;

    amo_queue #(.DEPTH(DEPTH), .PLEN(56), .XLEN(64), .TRANS_ID_BITS(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .amo_op_i(amo_op_i), .paddr_i(paddr_i), .data_i(data_i), .data_size_i(data_size_i),
        .trans_id_i(trans_id_i), .commit_i(commit_i), .no_st_pending_i(no_st_pending_i),
        .amo_req_req_o(amo_req_req_o), .amo_req_amo_op_o(amo_req_amo_op_o),
        .amo_req_size_o(amo_req_size_o), .amo_req_operand_a_o(amo_req_operand_a_o),
        .amo_req_operand_b_o(amo_req_operand_b_o), .amo_resp_ack_i(amo_resp_ack_i),
        .amo_resp_result_i(amo_resp_result_i), .result_valid_o(result_valid_o),
        .result_o(result_o), .result_trans_id_o(result_trans_id_o), .usage_o(usage_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  op;
        logic [55:0] paddr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [2:0]  id;
        bit          committed;
    } ent_t;

    ent_t        mq[$];
    bit          m_issued;
    bit          m_rv;
    logic [63:0] m_res;
    logic [2:0]  m_rid;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit model_req();
        return mq.size() > 0 && mq[0].committed && (no_st_pending_i || m_issued);
    endfunction

    function automatic bit model_has_unc();
        foreach (mq[i]) if (!mq[i].committed) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        valid_i = 0; commit_i = 0; flush_i = 0; amo_resp_ack_i = 0;
    endtask

    task automatic set_push(input logic [3:0] op, input logic [55:0] pa, input logic [63:0] d,
                            input logic [2:0] id);
        valid_i = 1; amo_op_i = op; paddr_i = pa; data_i = d; data_size_i = 2'd3; trans_id_i = id;
    endtask

    // Check outputs against the model, then advance the model across one clock edge.
    task automatic tick();
        bit   exp_req, pop;
        int   pre_size;
        ent_t e, kept[$];
        #1;
        exp_req = model_req();
        check("req", 64'(amo_req_req_o), 64'(exp_req));
        check("ready", 64'(ready_o), 64'(mq.size() < DEPTH));
        check("usage", 64'(usage_o), 64'(mq.size()));
        check("result_valid", 64'(result_valid_o), 64'(m_rv));
        if (exp_req) begin
            check("req_op", 64'(amo_req_amo_op_o), 64'(mq[0].op));
            check("req_size", 64'(amo_req_size_o), 64'(mq[0].size));
            check("operand_a", amo_req_operand_a_o, {8'h0, mq[0].paddr});
            check("operand_b", amo_req_operand_b_o, mq[0].data);
        end
        if (m_rv) begin
            check("result", result_o, m_res);
            check("result_id", 64'(result_trans_id_o), 64'(m_rid));
        end
        @(posedge clk_i);
        pop = amo_resp_ack_i && exp_req;
        m_rv = pop;
        if (pop) begin
            m_res = amo_resp_result_i;
            m_rid = mq[0].id;
        end
        if (pop) m_issued = 0;
        else if (exp_req) m_issued = 1;
        pre_size = mq.size();
        if (commit_i) begin
            for (int i = 0; i < mq.size(); i++)
                if (!mq[i].committed) begin mq[i].committed = 1; break; end
        end
        if (flush_i) begin
            foreach (mq[i]) if (mq[i].committed) kept.push_back(mq[i]);
            mq = kept;
        end
        if (pop) void'(mq.pop_front());
        if (valid_i && pre_size < DEPTH && !flush_i) begin
            e.op = amo_op_i; e.paddr = paddr_i; e.data = data_i; e.size = data_size_i;
            e.id = trans_id_i; e.committed = 0;
            mq.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            no_st_pending_i = 1;
            amo_resp_result_i = {$urandom, $urandom};
            amo_resp_ack_i = model_req();
            tick();
        end
        idle();
    endtask

    initial begin
        rst_ni = 0;
        idle();
        no_st_pending_i = 0;
        amo_op_i = 0; paddr_i = 0; data_i = 0; data_size_i = 0; trans_id_i = 0;
        amo_resp_result_i = 0;
        m_issued = 0; m_rv = 0; m_res = 0; m_rid = 0;
        repeat (2) @(negedge clk_i);
        check("rst_req", 64'(amo_req_req_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_usage", 64'(usage_o), 64'd0);
        check("rst_rv", 64'(result_valid_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_rid", 64'(result_trans_id_o), 64'd0);
        rst_ni = 1;

        // 1: single AMOADD, req held three cycles, result 7 with id 3
        no_st_pending_i = 1;
        set_push(4'h2, 56'h80, 64'd5, 3'd3); tick();
        idle(); commit_i = 1; tick();
        idle(); tick();
        check("t1_req_after_commit", 64'(amo_req_req_o), 64'd1);
        tick();
        amo_resp_result_i = 64'd7; amo_resp_ack_i = 1; tick();
        idle();
        check("t1_rv", 64'(result_valid_o), 64'd1);
        check("t1_result", result_o, 64'd7);
        check("t1_id", 64'(result_trans_id_o), 64'd3);
        tick();

        // 2: fill, third push ignored, in-order drain
        set_push(4'h3, 56'h100, 64'd11, 3'd0); tick();
        set_push(4'h3, 56'h108, 64'd12, 3'd1); tick();
        check("t2_full_ready", 64'(ready_o), 64'd0);
        check("t2_full_usage", 64'(usage_o), 64'd2);
        set_push(4'h3, 56'h110, 64'd13, 3'd2); tick();
        idle(); commit_i = 1; tick();
        commit_i = 1; tick();
        drain(8);

        // 3: flush drops the uncommitted entry, committed one still issues
        no_st_pending_i = 0;
        set_push(4'h4, 56'h200, 64'd21, 3'd4); tick();
        set_push(4'h5, 56'h208, 64'd22, 3'd5); tick();
        idle(); commit_i = 1; tick();
        idle(); flush_i = 1; tick();
        idle();
        check("t3_usage_after_flush", 64'(usage_o), 64'd1);
        drain(4);
        check("t3_usage_end", 64'(usage_o), 64'd0);
        check("t3_ready_end", 64'(ready_o), 64'd1);

        // 4: store buffer not empty holds the request; once raised it stays
        no_st_pending_i = 0;
        set_push(4'h6, 56'h300, 64'd31, 3'd6); tick();
        idle(); commit_i = 1; tick();
        idle();
        repeat (4) tick();
        no_st_pending_i = 1; tick();
        no_st_pending_i = 0; tick();
        check("t4_req_held", 64'(amo_req_req_o), 64'd1);
        amo_resp_result_i = 64'hdead; amo_resp_ack_i = 1; tick();
        idle(); tick();

        // 5: commit and flush together keep the entry
        no_st_pending_i = 0;
        set_push(4'h7, 56'h400, 64'd41, 3'd7); tick();
        idle(); commit_i = 1; flush_i = 1; tick();
        idle();
        check("t5_survives", 64'(usage_o), 64'd1);
        drain(4);

        // 6: asynchronous reset while a request is outstanding
        no_st_pending_i = 1;
        set_push(4'h1, 56'h500, 64'd51, 3'd2); tick();
        idle(); commit_i = 1; tick();
        idle(); tick();
        rst_ni = 0;
        #1;
        check("t6_req", 64'(amo_req_req_o), 64'd0);
        check("t6_usage", 64'(usage_o), 64'd0);
        check("t6_rv", 64'(result_valid_o), 64'd0);
        check("t6_ready", 64'(ready_o), 64'd1);
        mq.delete(); m_issued = 0; m_rv = 0; m_res = 0; m_rid = 0;
        @(negedge clk_i);
        rst_ni = 1;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                set_push(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
            data_size_i = 2'($urandom);
            commit_i = model_has_unc() && ($urandom_range(0, 2) == 0);
            flush_i = ($urandom_range(0, 11) == 0);
            no_st_pending_i = ($urandom_range(0, 3) != 0);
            amo_resp_result_i = {$urandom, $urandom};
            amo_resp_ack_i = model_req() && ($urandom_range(0, 2) == 0);
            tick();
        end
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
